// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder (mode 0, MSB first) serving READ, FAST READ and
// READ ID from an internal preloadable byte memory. The SPI pins are
// oversampled in the wb_clk_i domain.
module spi_flash_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 spi_clk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  input  logic                 load_we,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 busy,
  output logic                 bad_cmd
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_IGNORE
  } state_t;

  state_t state, state_nxt;

  logic sclk_m, sclk_s, sclk_q;
  logic cs_m, cs_s;
  logic mosi_m, mosi_s;
  logic sck_rise, sck_fall;

  logic [4:0]           cnt;
  logic [6:0]           cmd_sr;
  logic [7:0]           opc;
  logic [ADDR_BITS-2:0] addr_sr;
  logic [ADDR_BITS-1:0] addr;
  logic                 dummy;
  logic [6:0]           sr;
  logic [1:0]           id_idx;
  logic [7:0]           hold;
  logic [7:0]           src;

  logic [7:0] mem [2**ADDR_BITS];

  // Two-flop synchronizers for the asynchronous SPI pins plus SCK history.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sclk_m <= 1'b0; sclk_s <= 1'b0; sclk_q <= 1'b0;
      cs_m   <= 1'b1; cs_s   <= 1'b1;
      mosi_m <= 1'b0; mosi_s <= 1'b0;
    end else begin
      sclk_m <= spi_clk;  sclk_s <= sclk_m; sclk_q <= sclk_s;
      cs_m   <= spi_cs_n; cs_s   <= cs_m;
      mosi_m <= spi_mosi; mosi_s <= mosi_m;
    end
  end

  // Edges coinciding with deselect are dropped so chip select always wins.
  assign sck_rise = sclk_s & ~sclk_q & ~cs_s;
  assign sck_fall = ~sclk_s & sclk_q & ~cs_s;
  assign opc      = {cmd_sr, mosi_s};

  // Preload port and synchronous read; the holding register re-reads every
  // cycle, so a load to the pending address is seen until the byte is loaded
  // into the output shifter.
  always_ff @(posedge wb_clk_i) begin
    if (load_we) mem[load_addr] <= load_data;
    hold <= mem[addr];
  end

  // Byte source for the output shifter: memory in DATA, ID bytes in ID.
  always_comb begin
    src = hold;
    if (state == S_ID) begin
      case (id_idx)
        2'd0:    src = JEDEC_ID[23:16];
        2'd1:    src = JEDEC_ID[15:8];
        2'd2:    src = JEDEC_ID[7:0];
        default: src = 8'h00;
      endcase
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; deselect overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!cs_s) state_nxt = S_CMD;
      S_CMD:
        if (sck_rise && cnt == 5'd7) begin
          case (opc)
            8'h03, 8'h0B: state_nxt = S_ADDR;
            8'h9F:        state_nxt = S_ID;
            default:      state_nxt = S_IGNORE;
          endcase
        end
      S_ADDR:  if (sck_rise && cnt == 5'd23) state_nxt = dummy ? S_DUMMY : S_DATA;
      S_DUMMY: if (sck_rise && cnt == 5'd7) state_nxt = S_DATA;
      default: state_nxt = state;
    endcase
    if (cs_s) state_nxt = S_IDLE;
  end

  // Shifters, counters, address and output drivers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt <= '0; cmd_sr <= '0; addr_sr <= '0; addr <= '0; dummy <= 1'b0;
      sr <= '0; id_idx <= '0; spi_miso <= 1'b0; spi_miso_oe <= 1'b0;
      busy <= 1'b0; bad_cmd <= 1'b0;
    end else begin
      busy    <= ~cs_s;
      bad_cmd <= (state == S_CMD) && (state_nxt == S_IGNORE);
      case (state)
        S_CMD:
          if (sck_rise) begin
            cmd_sr <= opc[6:0];
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd7) dummy <= (opc == 8'h0B);
          end
        S_ADDR:
          if (sck_rise) begin
            addr_sr <= {addr_sr[ADDR_BITS-3:0], mosi_s};
            cnt     <= cnt + 5'd1;
            if (cnt == 5'd23) addr <= {addr_sr, mosi_s};
          end
        S_DUMMY:
          if (sck_rise) cnt <= cnt + 5'd1;
        S_DATA, S_ID:
          if (sck_fall) begin
            if (cnt[2:0] == 3'd0) begin
              sr          <= src[6:0];
              spi_miso    <= src[7];
              spi_miso_oe <= 1'b1;
              if (state == S_DATA)      addr   <= addr + ADDR_BITS'(1);
              else if (id_idx != 2'd3)  id_idx <= id_idx + 2'd1;
            end else begin
              sr       <= {sr[5:0], 1'b0};
              spi_miso <= sr[6];
            end
            cnt <= {2'b00, cnt[2:0] + 3'd1};
          end
        default: ;
      endcase
      if (state_nxt != state) begin
        cnt    <= '0;
        id_idx <= '0;
      end
      if (state_nxt != S_DATA && state_nxt != S_ID) spi_miso_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: table of flash transactions plus
// hand-written sequences for bad opcode, aborted address and mid-read reset.
module tb_spi_flash_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic       load_we;
  logic [9:0] load_addr;
  logic [7:0] load_data;
  logic       busy, bad_cmd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bad_cnt  = 0;
  int bad_cyc  = 0;
  int rise_cyc = 0;
  logic busy_ok;

  spi_flash_responder #(.ADDR_BITS(10), .JEDEC_ID(24'hEF4016)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .busy(busy), .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bad_cmd) begin
      bad_cnt = bad_cnt + 1;
      bad_cyc = cyc;
    end
  end

  typedef struct {
    logic [7:0]  opc;
    logic [23:0] adr;
    int          naddr;
    int          ndummy;
    int          nbytes;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [7:0] d);
    load_addr = a; load_data = d; load_we = 1'b1;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // n bits from tx[7] downward; MISO and OE sampled at each SCK rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx,
                          output logic oe_any, output logic oe_all);
    rx = '0; oe_any = 1'b0; oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      repeat (4) @(negedge clk);
      spi_clk  = 1'b1;
      rise_cyc = cyc;
      rx[7-i]  = spi_miso;
      oe_any   = oe_any | spi_miso_oe;
      oe_all   = oe_all & spi_miso_oe;
      busy_ok  = busy_ok & busy;
      repeat (4) @(negedge clk);
      spi_clk  = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    busy_ok  = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (2) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    logic [7:0] rx;
    logic a, al, pre_oe, data_oe;
    int bad0;
    bad0 = bad_cnt;
    pre_oe = 1'b0; data_oe = 1'b1;
    cs_begin();
    spi_bits(v.opc, 8, rx, a, al); pre_oe |= a;
    if (v.naddr != 0) begin
      spi_bits(v.adr[23:16], 8, rx, a, al); pre_oe |= a;
      spi_bits(v.adr[15:8],  8, rx, a, al); pre_oe |= a;
      spi_bits(v.adr[7:0],   8, rx, a, al); pre_oe |= a;
    end
    for (int d = 0; d < v.ndummy; d++) begin
      spi_bits(8'h00, 8, rx, a, al); pre_oe |= a;
    end
    for (int b = 0; b < v.nbytes; b++) begin
      spi_bits(8'h00, 8, rx, a, al);
      data_oe &= al;
      check($sformatf("vec%0d byte%0d", k, b), {24'h0, rx}, {24'h0, v.exp[31-8*b -: 8]});
    end
    check($sformatf("vec%0d oe_before_data", k), {31'h0, pre_oe}, 32'h0);
    check($sformatf("vec%0d oe_in_data", k), {31'h0, data_oe}, 32'h1);
    check($sformatf("vec%0d busy_cs_low", k), {31'h0, busy_ok}, 32'h1);
    cs_end();
    check($sformatf("vec%0d oe_after_cs", k), {31'h0, spi_miso_oe}, 32'h0);
    check($sformatf("vec%0d busy_after_cs", k), {31'h0, busy}, 32'h0);
    check($sformatf("vec%0d no_bad_cmd", k), bad_cnt - bad0, 32'h0);
  endtask

  initial begin
    logic [7:0] rx;
    logic a, al;
    int bad0;

    vecs[0] = '{8'h03, 24'h000010, 1, 0, 2, 32'hA53C_0000};
    vecs[1] = '{8'h03, 24'hFFF3FF, 1, 0, 2, 32'h1122_0000};
    vecs[2] = '{8'h0B, 24'h000010, 1, 1, 1, 32'hA500_0000};
    vecs[3] = '{8'h9F, 24'h000000, 0, 0, 4, 32'hEF40_1600};
    vecs[4] = '{8'h03, 24'h000011, 1, 0, 1, 32'h3C00_0000};
    vecs[5] = '{8'h0B, 24'h0003FF, 1, 1, 2, 32'h1122_0000};

    rst = 1'b1; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    check("rst miso", {31'h0, spi_miso}, 32'h0);
    check("rst oe", {31'h0, spi_miso_oe}, 32'h0);
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst bad_cmd", {31'h0, bad_cmd}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    load(10'h010, 8'hA5);
    load(10'h011, 8'h3C);
    load(10'h3FF, 8'h11);
    load(10'h000, 8'h22);
    repeat (2) @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Unsupported opcode: single bad_cmd pulse, then no drive until deselect.
    bad0 = bad_cnt;
    cs_begin();
    spi_bits(8'h02, 8, rx, a, al);
    check("bad pulse count", bad_cnt - bad0, 32'd1);
    check("bad pulse timing", bad_cyc - rise_cyc, 32'd3);
    spi_bits(8'hFF, 8, rx, a, al);
    check("ignore oe byte1", {31'h0, a}, 32'h0);
    spi_bits(8'h03, 8, rx, a, al);
    check("ignore oe byte2", {31'h0, a}, 32'h0);
    check("bad single pulse", bad_cnt - bad0, 32'd1);
    cs_end();
    run_vec(10, vecs[0]);

    // Deselect after 12 address bits, then a full read.
    cs_begin();
    spi_bits(8'h03, 8, rx, a, al);
    spi_bits(8'h00, 8, rx, a, al);
    spi_bits(8'h00, 4, rx, a, al);
    cs_end();
    check("abort oe", {31'h0, spi_miso_oe}, 32'h0);
    run_vec(11, vecs[0]);

    // Reset in the middle of the data phase.
    cs_begin();
    spi_bits(8'h03, 8, rx, a, al);
    spi_bits(8'h00, 8, rx, a, al);
    spi_bits(8'h00, 8, rx, a, al);
    spi_bits(8'h10, 8, rx, a, al);
    spi_bits(8'h00, 4, rx, a, al);
    check("pre-reset oe", {31'h0, spi_miso_oe}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("reset oe", {31'h0, spi_miso_oe}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    cs_end();
    run_vec(12, vecs[0]);
    run_vec(13, vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
